// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vend_pkg
// Purpose  : Shared coin codes, state type and coin-value lookup for vend_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
package vend_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_1    = 2'b01;
    localparam logic [1:0] COIN_2    = 2'b10;
    localparam logic [1:0] COIN_3    = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        CHANGE  = 2'd3
    } vend_state_t;

    function automatic int unsigned coin_value(
        input logic [1:0]  code,
        input int unsigned v1,
        input int unsigned v2,
        input int unsigned v3
    );
        case (code)
            COIN_1:  return v1;
            COIN_2:  return v2;
            COIN_3:  return v3;
            default: return 0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/vend_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : vend_ctrl_if
// Purpose  : Coin, vend and change handshake bundle around vend_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface vend_ctrl_if #(
    parameter int CRED_W = 8,
    parameter int CNT_W  = 16
) ();
    logic [1:0]        inp;
    logic              cancel;
    logic              vend_ready;
    logic              chg_ready;
    logic              coin_ready;
    logic              coin_rej;
    logic              out;
    logic              chg_valid;
    logic [CRED_W-1:0] credit;
    logic [CNT_W-1:0]  vend_cnt;

    // master is the controller itself; slave is the acceptor/dispenser side
    modport master (
        input  inp, cancel, vend_ready, chg_ready,
        output coin_ready, coin_rej, out, chg_valid, credit, vend_cnt
    );

    modport slave (
        output inp, cancel, vend_ready, chg_ready,
        input  coin_ready, coin_rej, out, chg_valid, credit, vend_cnt
    );
endinterface
`default_nettype wire

// File: rtl/vend_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vend_ctrl
// Purpose  : Coin credit accumulator with vend handshake and coin-by-coin change.
// Revision : 1.0 - initial release
// ============================================================================
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int PRICE     = 15,
    parameter int COIN1_VAL = 5,
    parameter int COIN2_VAL = 10,
    parameter int COIN3_VAL = 20,
    parameter int CHG_VAL   = 5,
    parameter int CRED_W    = 8,
    parameter int CNT_W     = 16
) (
    input  wire logic    clk,
    input  wire logic    rst,
    vend_ctrl_if.master  bus
);

    localparam int MAX_COIN = (COIN1_VAL > COIN2_VAL)
                            ? ((COIN1_VAL > COIN3_VAL) ? COIN1_VAL : COIN3_VAL)
                            : ((COIN2_VAL > COIN3_VAL) ? COIN2_VAL : COIN3_VAL);

    localparam logic [CRED_W-1:0] C_PRICE = CRED_W'(PRICE);
    localparam logic [CRED_W-1:0] C_CHG   = CRED_W'(CHG_VAL);

    if (PRICE <= 0 || CHG_VAL <= 0) begin : g_bad_value
        $error("vend_ctrl: PRICE and CHG_VAL must be positive");
    end

    if ((PRICE % CHG_VAL) != 0 || (COIN1_VAL % CHG_VAL) != 0 ||
        (COIN2_VAL % CHG_VAL) != 0 || (COIN3_VAL % CHG_VAL) != 0) begin : g_bad_multiple
        $error("vend_ctrl: PRICE and coin values must be multiples of CHG_VAL");
    end

    if ((PRICE - 1 + MAX_COIN) >= (1 << CRED_W)) begin : g_bad_cred_w
        $error("vend_ctrl: CRED_W too narrow for PRICE-1+max coin value");
    end

    vend_state_t       state_q, state_d;
    logic [CRED_W-1:0] credit_q, credit_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rej_q, rej_d;

    logic              w_coin_ready;
    logic              w_coin_in;
    logic [CRED_W-1:0] w_coin_val;
    logic [CRED_W-1:0] w_sum;

    assign w_coin_ready = ((state_q == IDLE) || (state_q == COLLECT)) && !bus.cancel;
    assign w_coin_in    = (bus.inp != COIN_NONE);
    assign w_coin_val   = CRED_W'(coin_value(bus.inp, COIN1_VAL, COIN2_VAL, COIN3_VAL));
    // Cannot wrap: credit stays below PRICE while coins are being accepted
    assign w_sum        = credit_q + w_coin_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            credit_q <= '0;
            cnt_q    <= '0;
            rej_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            cnt_q    <= cnt_d;
            rej_q    <= rej_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        cnt_d    = cnt_q;
        rej_d    = w_coin_in && !w_coin_ready;

        case (state_q)
            IDLE, COLLECT: begin
                if (w_coin_ready && w_coin_in) begin
                    if (w_sum >= C_PRICE) begin
                        credit_d = w_sum - C_PRICE;
                        state_d  = VEND;
                    end else begin
                        credit_d = w_sum;
                        state_d  = COLLECT;
                    end
                end else if ((state_q == COLLECT) && bus.cancel) begin
                    state_d = CHANGE;
                end
            end
            VEND: begin
                if (bus.vend_ready) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = (credit_q != '0) ? CHANGE : IDLE;
                end
            end
            CHANGE: begin
                // Credit here is always a nonzero multiple of CHG_VAL
                if (bus.chg_ready) begin
                    credit_d = credit_q - C_CHG;
                    if (credit_q == C_CHG) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.coin_ready = w_coin_ready;
    assign bus.coin_rej   = rej_q;
    assign bus.out        = (state_q == VEND);
    assign bus.chg_valid  = (state_q == CHANGE);
    assign bus.credit     = credit_q;
    assign bus.vend_cnt   = cnt_q;

endmodule
`default_nettype wire

// File: doc/vend_ctrl.md
# vend_ctrl

Parametrised successor to the single-product coin vending FSM. Accepts up to three coin denominations, accumulates credit against a configurable price, issues a vend request with a valid/ready handshake, and returns change or refunds one coin at a time over a second handshake. It sits between the coin-acceptor front end and the dispenser and change-hopper drivers.

## Interface
- `PRICE`, default 15: product price in rupees; >0.
- `COIN1_VAL`, default 5: value of code 2'b01.
- `COIN2_VAL`, default 10: value of code 2'b10.
- `COIN3_VAL`, default 20: value of code 2'b11.
- `CHG_VAL`, default 5: value of one returned coin. PRICE and all COINn_VAL are multiples of CHG_VAL (elaboration-time check).
- `CRED_W`, default 8: credit width; must hold PRICE-1+max(COINn_VAL).
- `CNT_W`, default 16: vend counter width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `inp` in 2: coin code; 00 none, 01/10/11 COIN1/2/3. Held for one cycle per coin.
- `cancel` in 1: refund request.
- `vend_ready` in 1: dispenser accepts vend.
- `chg_ready` in 1: hopper accepts one change coin.
- `coin_ready` out 1: coin is accepted this cycle.
- `coin_rej` out 1: one-cycle pulse; previous-cycle coin was rejected and must be returned mechanically.
- `out` out 1: vend valid.
- `chg_valid` out 1: return one CHG_VAL coin.
- `credit` out CRED_W: current credit.
- `vend_cnt` out CNT_W: completed vends, wraps.

## Operation
- States: IDLE (credit 0), COLLECT (0<credit<PRICE), VEND, CHANGE.
- `coin_ready` = 1 in IDLE/COLLECT and `cancel` low. `out` = 1 only in VEND. `chg_valid` = 1 only in CHANGE.
- Coin accepted when `coin_ready` and `inp`≠0. Sum = credit+value.
  - Sum ≥ PRICE: credit ← sum−PRICE, go VEND.
  - Otherwise credit ← sum, go COLLECT.
- VEND: hold `out` until `vend_ready`. On handshake, increment `vend_cnt` (wraps modulo 2^CNT_W). Go CHANGE if credit>0, else IDLE.
- CHANGE: each `chg_valid`&&`chg_ready` cycle, credit ← credit−CHG_VAL. When the handshake brings credit to 0, go IDLE.
- `cancel` in COLLECT: go CHANGE with credit unchanged (full refund).
- `cancel` in IDLE, VEND or CHANGE: ignored.
- Coin with `cancel` high, or any nonzero `inp` while in VEND/CHANGE: not added. `coin_rej` pulses the next cycle.
- Invalid codes cannot occur; all four codes are defined.
- No overflow is possible because VEND is entered whenever sum ≥ PRICE.

## Timing
- Reset (async, any state including mid-handshake): state IDLE, credit 0, `vend_cnt` 0. Outputs: `out` 0, `chg_valid` 0, `coin_rej` 0, `coin_ready` 1 (given `cancel` low). Any pending vend or change is lost.
- All outputs except `coin_ready` are registered. `coin_ready` is combinational on state and `cancel`.
- Coin on cycle N: `credit` and state update visible at N+1. `out` rises at N+1 if price is reached.
- Vend handshake at cycle M: `out` low at M+1, `chg_valid` high at M+1 if change is due.
- Change: one coin per handshake cycle; back-to-back handshakes are allowed. `chg_valid` drops the cycle after the final handshake.
- `coin_rej` is asserted exactly one cycle, the cycle after the offending coin.
- Minimum vend latency, first coin to `out`: 1 cycle.

## Structure
- Shared package `vend_pkg`:
  - Coin code constants COIN_NONE/COIN_1/COIN_2/COIN_3.
  - State typedef `vend_state_t` {IDLE, COLLECT, VEND, CHANGE}.
  - Coin-value lookup function.
- Single module. Do not split into sub-modules; the change return is a decrement on `credit`, not a separate block.

## Test plan
Defaults apply: PRICE=15, coins 5/10/20, CHG_VAL=5.
- Coins 5 then 10, `vend_ready`=1 → `out` for 1 cycle; credit 0; IDLE; `vend_cnt`=1; no `chg_valid`.
- Coin 20 with `vend_ready` low 3 cycles → `out` held 4 cycles; then one `chg_valid` coin; credit 5→0.
- Coins 10, 10 → VEND, credit 5. A coin 5 presented during VEND → `coin_rej` pulse next cycle, credit stays 5. Then 1 change coin.
- Coins 5, 5 then `cancel` → two `chg_valid` handshakes. With `chg_ready` toggling 1,0,1, `chg_valid` is high for 3 cycles; credit ends 0, `vend_cnt` unchanged.
- Coin 5 with `cancel` high in COLLECT → `coin_rej` pulse; full refund of prior credit only.
- Assert `rst` asynchronously mid-CHANGE (credit 10) → credit 0, `chg_valid` 0 immediately, IDLE. 2^CNT_W vends (CNT_W=4) → `vend_cnt` wraps to 0.
